// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Initiator for a combinational 8-bit ALU. Commands arrive over a valid/ready
//   port and are buffered in a small FIFO. They are then driven one at a time
//   onto alu_op/alu_a/alu_b. After SETTLE cycles alu_res is captured and
//   returned on a valid/ready response port.
//
//   Optional feature (macro ALU_SEQ_DIVZERO_CHK_EN): a divide (op 3) with
//   B == 0 is not issued to the ALU. Instead it is answered directly with
//   res=FF and err=1. When the macro is undefined, rsp_err is always 0.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready = !fifo_full)
//   cmd_op/cmd_a/cmd_b          command payload
//   alu_op/alu_a/alu_b          registered drive to the ALU
//   alu_res                     ALU result
//   rsp_valid/rsp_ready         response handshake
//   rsp_res/rsp_op/rsp_err      response payload, held stable while valid
//   busy                        FSM not idle or FIFO non-empty
//   cnt_issued                  completed responses, wraps modulo 2^CNT_W
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic [3:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_res,
  output logic [3:0]       rsp_op,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_issued
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // FIFO entry layout: {op[19:16], a[15:8], b[7:0]}
  logic [19:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic [1:0]       r_state;
  logic [SW-1:0]    r_cnt;
  logic [3:0]       r_alu_op, r_rsp_op;
  logic [7:0]       r_alu_a, r_alu_b, r_rsp_res;
  logic             r_rsp_valid, r_rsp_err;
  logic [CNT_W-1:0] r_cnt_issued;

  logic        w_full, w_empty, w_push, w_pop, w_divz;
  logic [19:0] w_head;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_valid & ~w_full;
  // Popping only from IDLE means a push into an empty FIFO is seen no
  // earlier than the following edge.
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;
  assign w_head  = r_mem[r_rptr];

`ifdef ALU_SEQ_DIVZERO_CHK_EN
  assign w_divz = (w_head[19:16] == 4'd3) && (w_head[7:0] == 8'h00);
`else
  assign w_divz = 1'b0;
`endif

  // FIFO storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_op     <= '0;
      r_rsp_res    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_cnt_issued <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_rsp_op  <= w_head[19:16];
          r_rsp_err <= w_divz;
          if (w_divz) begin
            // Rejected divide: the ALU inputs keep their previous values.
            r_rsp_res   <= 8'hFF;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_alu_op <= w_head[19:16];
            r_alu_a  <= w_head[15:8];
            r_alu_b  <= w_head[7:0];
            r_cnt    <= SW'(SETTLE - 1);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_res   <= alu_res;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: if (rsp_ready) begin
          r_rsp_valid  <= 1'b0;
          r_cnt_issued <= r_cnt_issued + 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = ~w_full;
  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_res    = r_rsp_res;
  assign rsp_op     = r_rsp_op;
  assign rsp_err    = r_rsp_err;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign cnt_issued = r_cnt_issued;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  logic clk;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 8'd0) ? 8'hFF : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      default: return 8'd0;
    endcase
  endfunction

  // Instance A: SETTLE=1, defaults
  logic       a_rst, a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [3:0] a_cmd_op, a_alu_op, a_rsp_op;
  logic [7:0] a_cmd_a, a_cmd_b, a_alu_a, a_alu_b, a_alu_res, a_rsp_res;
  logic [15:0] a_cnt;
  assign a_alu_res = alu_f(a_alu_op, a_alu_a, a_alu_b);

  alu_cmd_sequencer u_dut_a (
    .clk(clk), .rst(a_rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_op(a_cmd_op), .cmd_a(a_cmd_a), .cmd_b(a_cmd_b),
    .alu_op(a_alu_op), .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_res(a_alu_res),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_res(a_rsp_res),
    .rsp_op(a_rsp_op), .rsp_err(a_rsp_err), .busy(a_busy), .cnt_issued(a_cnt)
  );

  // Instance B: SETTLE=4, CNT_W=4
  logic       b_rst, b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [3:0] b_cmd_op, b_alu_op, b_rsp_op;
  logic [7:0] b_cmd_a, b_cmd_b, b_alu_a, b_alu_b, b_alu_res, b_rsp_res;
  logic [3:0] b_cnt;
  assign b_alu_res = alu_f(b_alu_op, b_alu_a, b_alu_b);

  alu_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE(4), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(b_rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(b_cmd_op), .cmd_a(b_cmd_a), .cmd_b(b_cmd_b),
    .alu_op(b_alu_op), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_res(b_alu_res),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_res(b_rsp_res),
    .rsp_op(b_rsp_op), .rsp_err(b_rsp_err), .busy(b_busy), .cnt_issued(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    a_cmd_valid = 1'b1; a_cmd_op = op; a_cmd_a = a; a_cmd_b = b;
    tick();
    a_cmd_valid = 1'b0;
  endtask

  task automatic push_b(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    b_cmd_valid = 1'b1; b_cmd_op = op; b_cmd_a = a; b_cmd_b = b;
    tick();
    b_cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_acc;
    int n_got;
    logic [7:0] got [5];

    clk = 1'b0;
    a_rst = 1'b1; a_cmd_valid = 1'b0; a_cmd_op = '0; a_cmd_a = '0; a_cmd_b = '0; a_rsp_ready = 1'b0;
    b_rst = 1'b1; b_cmd_valid = 1'b0; b_cmd_op = '0; b_cmd_a = '0; b_cmd_b = '0; b_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset state
    chk("rst_cmd_ready", 32'(a_cmd_ready), 1);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 0);
    chk("rst_busy",      32'(a_busy), 0);
    chk("rst_cnt",       32'(a_cnt), 0);
    chk("rst_alu_a",     32'(a_alu_a), 0);
    chk("rst_rsp_err",   32'(a_rsp_err), 0);

    // 1: single add, latency
    push_a(4'd0, 8'd3, 8'd5);
    chk("t1_rsp_valid_early", 32'(a_rsp_valid), 0);
    tick();
    chk("t1_alu_op", 32'(a_alu_op), 0);
    chk("t1_alu_a",  32'(a_alu_a), 3);
    chk("t1_alu_b",  32'(a_alu_b), 5);
    chk("t1_rsp_valid_wait", 32'(a_rsp_valid), 0);
    tick();
    chk("t1_rsp_valid", 32'(a_rsp_valid), 1);
    chk("t1_rsp_res",   32'(a_rsp_res), 8);
    chk("t1_rsp_op",    32'(a_rsp_op), 0);
    chk("t1_busy",      32'(a_busy), 1);
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    chk("t1_rsp_valid_done", 32'(a_rsp_valid), 0);
    chk("t1_cnt", 32'(a_cnt), 1);

    // 2: fill to capacity with responses blocked
    n_acc = 0;
    for (int i = 1; i <= 7; i++) begin
      a_cmd_valid = 1'b1; a_cmd_op = 4'd0; a_cmd_a = 8'(i); a_cmd_b = 8'd1;
      if (a_cmd_ready) n_acc++;
      tick();
    end
    a_cmd_valid = 1'b0;
    chk("t2_accepted", 32'(n_acc), 5);
    chk("t2_cmd_ready_full", 32'(a_cmd_ready), 0);

    // 3: stalled response stays stable, no pop
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("t3_rsp_valid_%0d", c), 32'(a_rsp_valid), 1);
      chk($sformatf("t3_rsp_res_%0d", c),   32'(a_rsp_res), 2);
      chk($sformatf("t3_alu_a_%0d", c),     32'(a_alu_a), 1);
      chk($sformatf("t3_cmd_ready_%0d", c), 32'(a_cmd_ready), 0);
      tick();
    end

    // Drain in order
    a_rsp_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 60 && n_got < 5; c++) begin
      if (a_rsp_valid) begin
        got[n_got] = a_rsp_res;
        n_got++;
      end
      tick();
    end
    a_rsp_ready = 1'b0;
    chk("t2_num_rsp", 32'(n_got), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t2_rsp_%0d", k), 32'(got[k]), 32'(k + 2));
    chk("t2_busy_idle", 32'(a_busy), 0);
    chk("t2_cnt", 32'(a_cnt), 6);

    // 5: divide by zero
    push_a(4'd3, 8'd9, 8'd0);
    tick();
`ifdef ALU_SEQ_DIVZERO_CHK_EN
    chk("t5_dz_valid", 32'(a_rsp_valid), 1);
    chk("t5_dz_err",   32'(a_rsp_err), 1);
    chk("t5_dz_res",   32'(a_rsp_res), 32'h00FF);
    chk("t5_dz_op",    32'(a_rsp_op), 3);
    chk("t5_dz_alu_op", 32'(a_alu_op), 0);
    chk("t5_dz_alu_a",  32'(a_alu_a), 5);
    chk("t5_dz_alu_b",  32'(a_alu_b), 1);
`else
    chk("t5_dz_valid_early", 32'(a_rsp_valid), 0);
    chk("t5_dz_alu_op", 32'(a_alu_op), 3);
    chk("t5_dz_alu_a",  32'(a_alu_a), 9);
    chk("t5_dz_alu_b",  32'(a_alu_b), 0);
    tick();
    chk("t5_dz_valid", 32'(a_rsp_valid), 1);
    chk("t5_dz_err",   32'(a_rsp_err), 0);
    chk("t5_dz_res",   32'(a_rsp_res), 32'h00FF);
    chk("t5_dz_op",    32'(a_rsp_op), 3);
`endif
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    chk("t5_dz_done", 32'(a_rsp_valid), 0);
    push_a(4'd3, 8'd9, 8'd3);
    tick();
    tick();
    chk("t5_div_valid", 32'(a_rsp_valid), 1);
    chk("t5_div_res",   32'(a_rsp_res), 3);
    chk("t5_div_err",   32'(a_rsp_err), 0);
    chk("t5_div_op",    32'(a_rsp_op), 3);
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    chk("t5_cnt", 32'(a_cnt), 8);

    // 4: SETTLE=4, reset in the middle of WAIT
    push_b(4'd1, 8'd9, 8'd4);
    tick();
    chk("t4_alu_a", 32'(b_alu_a), 9);
    tick();
    tick();
    b_rst = 1'b1;
    #1;
    chk("t4_rst_rsp_valid", 32'(b_rsp_valid), 0);
    chk("t4_rst_cmd_ready", 32'(b_cmd_ready), 1);
    chk("t4_rst_busy",      32'(b_busy), 0);
    chk("t4_rst_cnt",       32'(b_cnt), 0);
    chk("t4_rst_alu_a",     32'(b_alu_a), 0);
    tick();
    b_rst = 1'b0;
    push_b(4'd1, 8'd9, 8'd4);
    repeat (4) tick();
    chk("t4_valid_early", 32'(b_rsp_valid), 0);
    tick();
    chk("t4_valid", 32'(b_rsp_valid), 1);
    chk("t4_res",   32'(b_rsp_res), 5);
    chk("t4_op",    32'(b_rsp_op), 1);
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
    chk("t4_cnt", 32'(b_cnt), 1);

    // 6: CNT_W=4 wrap, commands 2..17
    for (int k = 2; k <= 17; k++) begin
      push_b(4'd0, 8'(k), 8'd0);
      for (int c = 0; c < 20 && !b_rsp_valid; c++) tick();
      chk($sformatf("t6_valid_%0d", k), 32'(b_rsp_valid), 1);
      chk($sformatf("t6_res_%0d", k),   32'(b_rsp_res), 32'(k));
      b_rsp_ready = 1'b1;
      tick();
      b_rsp_ready = 1'b0;
      chk($sformatf("t6_cnt_%0d", k), 32'(b_cnt), 32'(k % 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
